uart_cmd_loader: RTL and testbench
==================================

Name: uart_cmd_loader

Overview:
Parametrised host-command loader between the UART controller byte stream and the core's memories. Parses framed commands (PING, IMEM write, BMEM block write, thread-state UPDATE) from received bytes. Drives write strobes to N per-thread instruction memories and the block memory. Returns a one-byte ACK/NAK/PING response per command, and aborts partial commands on an inter-byte timeout.

Parameters:
BITWIDTH, 16, address/data word width; must be a multiple of 8; BYTES = BITWIDTH/8
NUM_THREADS, 3, number of imem channels/threads (1..6)
BMEM_WORDS, 16, words per BMEM block write (MESHUNITS^2*TILEUNITS^2)
TIMEOUT_CYCLES, 1_000_000, max idle cycles between bytes of one command

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from UART controller
rx_valid  in  1  rx_data valid; one-cycle pulse per byte; no backpressure
tx_data  out  8  response byte
tx_valid  out  1  response pending
tx_ready  in  1  UART accepts tx_data when tx_valid&tx_ready
addr_out  out  BITWIDTH  assembled write address
imem_data  out  BITWIDTH  assembled imem word
imem_write_valid  out  NUM_THREADS  one-hot imem write strobe
bmem_data  out  BMEM_WORDS*BITWIDTH  assembled block; word i at [i*BITWIDTH +: BITWIDTH]
bmem_write_valid  out  1  bmem write strobe
thread_running  out  NUM_THREADS  current running mask
busy  out  1  high while FSM is not in START

Behaviour:
- Reset: all outputs 0; FSM -> START; byte counter 0; timeout counter 0; pending response cleared.
- Multi-byte fields are little-endian: byte k goes to bits [8k+7:8k]. BMEM words arrive in order 0..BMEM_WORDS-1; each word is little-endian.
- Header decode in START uses rx_data[7:6]:
  - 00 PING: stay in START; respond 0x5A.
  - 01 IMEM: go to IMEM_ADDR.
  - 10 BMEM: go to BMEM_ADDR.
  - 11 UPDATE: thread_running <= rx_data[NUM_THREADS-1:0] on the next edge; respond ACK 0x06; stay in START.
- IMEM_ADDR / BMEM_ADDR: collect BYTES bytes into addr_out, then go to IMEM_DATA / BMEM_DATA with the counter cleared.
- IMEM_DATA: collect BYTES bytes. The cycle after the last byte's rx_valid:
  - Target is the lowest-index thread t with thread_running[t]==0. Pulse imem_write_valid[t] for 1 cycle and respond ACK.
  - If all threads are running: no strobe, respond NAK 0x15.
  - Return to START.
- BMEM_DATA: collect BYTES*BMEM_WORDS bytes. The cycle after the last byte: pulse bmem_write_valid for 1 cycle, respond ACK, return to START.
- Stability: strobes are exactly one cycle wide. addr_out, imem_data and bmem_data hold their values from the strobe cycle until overwritten by bytes of a later command.
- Response timing: tx_valid rises in the same cycle as the strobe (or the cycle after a PING/UPDATE header) and holds with tx_data stable until tx_valid&tx_ready. If a new response is produced while one is still pending, the new one replaces it (latest wins).
- Timeout: a counter runs while busy and clears on every rx_valid. When it reaches TIMEOUT_CYCLES with no byte: return to START, issue no strobe, respond NAK, discard the partial command. Headers are never subject to timeout.
- An UPDATE landing mid-command is impossible by construction: all bytes are consumed by the active command.
- Reset mid-command: abort immediately; no strobe is issued, including when reset coincides with the last byte.
- Simultaneous rx_valid and timeout expiry: the byte wins and the counter clears.

Test Plan:
- BITWIDTH=16, NUM_THREADS=3, mask=000; send 0x40,0x34,0x12,0xCD,0xAB -> one cycle later addr_out=0x1234, imem_data=0xABCD, imem_write_valid=001, tx_data=0x06 held until tx_ready.
- Send UPDATE 0xC3 (mask 011), then the same IMEM command -> imem_write_valid=100. Then UPDATE 0xC7 and IMEM -> no strobe, tx_data=0x15.
- BMEM_WORDS=4; send 0x80, addr 0x10,0x00, bytes 0x01..0x08 -> bmem_write_valid pulse, addr_out=0x0010, bmem_data=0x0807_0605_0403_0201.
- TIMEOUT_CYCLES=50; send 0x40,0x34 then idle 50 cycles -> busy falls, NAK 0x15, no strobe. A following PING 0x00 -> 0x5A.
- Assert reset in the same cycle as the last IMEM byte -> no strobe; all outputs 0; next full command works normally.
- Hold tx_ready=0 across two PINGs -> tx_valid stays high with 0x5A. Raise tx_ready -> single transfer, then tx_valid=0.

Source files
------------

// File: rtl/uart_cmd_loader.sv
// Host command loader: parses framed UART bytes (PING / IMEM / BMEM / UPDATE) into
// memory write strobes and returns one response byte per command.
module uart_cmd_loader #(
  parameter int BITWIDTH       = 16,
  parameter int NUM_THREADS    = 3,
  parameter int BMEM_WORDS     = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [BITWIDTH-1:0]            addr_out,
  output logic [BITWIDTH-1:0]            imem_data,
  output logic [NUM_THREADS-1:0]         imem_write_valid,
  output logic [BMEM_WORDS*BITWIDTH-1:0] bmem_data,
  output logic                           bmem_write_valid,
  output logic [NUM_THREADS-1:0]         thread_running,
  output logic                           busy
);

  localparam int BYTES      = BITWIDTH / 8;
  localparam int BMEM_BYTES = BYTES * BMEM_WORDS;
  localparam int CNT_W      = $clog2(BMEM_BYTES + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FIELD_LAST   = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] BMEM_LAST    = CNT_W'(BMEM_BYTES - 1);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_PING = 8'h5A;

  typedef enum logic [2:0] {
    START,
    IMEM_ADDR,
    IMEM_DATA,
    BMEM_ADDR,
    BMEM_DATA
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       byte_cnt;
  logic [TO_W-1:0]        idle_cnt;
  logic [NUM_THREADS-1:0] free_onehot;
  logic                   timeout_hit;

  // Lowest-index idle thread receives the IMEM word; all-zero means every thread runs.
  always_comb begin
    logic found;
    // NOTE: every always_comb output gets a default first, otherwise paths that skip the assignment infer a latch.
    free_onehot = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!thread_running[i] && !found) begin
        free_onehot[i] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = busy && !rx_valid && (idle_cnt == TIMEOUT_LAST);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the bmem_data block is a wide output register, not a RAM, so it is cleared like any other output.
      state            <= START;
      byte_cnt         <= '0;
      idle_cnt         <= '0;
      busy             <= 1'b0;
      tx_data          <= '0;
      tx_valid         <= 1'b0;
      addr_out         <= '0;
      imem_data        <= '0;
      imem_write_valid <= '0;
      bmem_data        <= '0;
      bmem_write_valid <= 1'b0;
      thread_running   <= '0;
    end else begin
      imem_write_valid <= '0;
      bmem_write_valid <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;

      if (rx_valid || !busy) idle_cnt <= '0;
      else                   idle_cnt <= idle_cnt + TO_W'(1);

      // Later response writes below override the handshake clear: latest response wins.
      if (timeout_hit) begin
        state    <= START;
        busy     <= 1'b0;
        byte_cnt <= '0;
        idle_cnt <= '0;
        tx_data  <= RSP_NAK;
        tx_valid <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          START: begin
            case (rx_data[7:6])
              2'b00: begin
                tx_data  <= RSP_PING;
                tx_valid <= 1'b1;
              end
              2'b01: begin
                state <= IMEM_ADDR;
                busy  <= 1'b1;
              end
              2'b10: begin
                state <= BMEM_ADDR;
                busy  <= 1'b1;
              end
              default: begin
                thread_running <= rx_data[NUM_THREADS-1:0];
                tx_data        <= RSP_ACK;
                tx_valid       <= 1'b1;
              end
            endcase
          end

          IMEM_ADDR, BMEM_ADDR: begin
            addr_out[8*int'(byte_cnt) +: 8] <= rx_data;
            if (byte_cnt == FIELD_LAST) begin
              byte_cnt <= '0;
              state    <= (state == IMEM_ADDR) ? IMEM_DATA : BMEM_DATA;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end

          IMEM_DATA: begin
            imem_data[8*int'(byte_cnt) +: 8] <= rx_data;
            if (byte_cnt == FIELD_LAST) begin
              byte_cnt         <= '0;
              state            <= START;
              busy             <= 1'b0;
              imem_write_valid <= free_onehot;
              tx_data          <= (|free_onehot) ? RSP_ACK : RSP_NAK;
              tx_valid         <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end

          BMEM_DATA: begin
            // Word i byte k lands at byte offset i*BYTES+k, which is exactly the running count.
            bmem_data[8*int'(byte_cnt) +: 8] <= rx_data;
            if (byte_cnt == BMEM_LAST) begin
              byte_cnt         <= '0;
              state            <= START;
              busy             <= 1'b0;
              bmem_write_valid <= 1'b1;
              tx_data          <= RSP_ACK;
              tx_valid         <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end

          default: begin
            state <= START;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Self-checking bench for uart_cmd_loader: directed scenarios plus randomized commands
// compared against a command-level reference model.
module tb_uart_cmd_loader;

  localparam int BITWIDTH       = 16;
  localparam int NUM_THREADS    = 3;
  localparam int BMEM_WORDS     = 4;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int BYTES          = BITWIDTH / 8;

  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  localparam logic [7:0] PING = 8'h5A;

  logic                           clock;
  logic                           reset;
  logic [7:0]                     rx_data;
  logic                           rx_valid;
  logic [7:0]                     tx_data;
  logic                           tx_valid;
  logic                           tx_ready;
  logic [BITWIDTH-1:0]            addr_out;
  logic [BITWIDTH-1:0]            imem_data;
  logic [NUM_THREADS-1:0]         imem_write_valid;
  logic [BMEM_WORDS*BITWIDTH-1:0] bmem_data;
  logic                           bmem_write_valid;
  logic [NUM_THREADS-1:0]         thread_running;
  logic                           busy;

  uart_cmd_loader #(
    .BITWIDTH      (BITWIDTH),
    .NUM_THREADS   (NUM_THREADS),
    .BMEM_WORDS    (BMEM_WORDS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .addr_out        (addr_out),
    .imem_data       (imem_data),
    .imem_write_valid(imem_write_valid),
    .bmem_data       (bmem_data),
    .bmem_write_valid(bmem_write_valid),
    .thread_running  (thread_running),
    .busy            (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int   model_mask;
  logic [BMEM_WORDS*BITWIDTH-1:0] model_bmem;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Response must be present, hold while not accepted, and clear after one handshake.
  task automatic expect_resp(input string tag, input logic [7:0] code);
    check({tag, "/tx_valid"}, 64'(tx_valid), 64'd1);
    check({tag, "/tx_data"}, 64'(tx_data), 64'(code));
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    check({tag, "/tx_drained"}, 64'(tx_valid), 64'd0);
  endtask

  task automatic run_ping(input string tag);
    send_byte(8'($urandom_range(0, 63)), 0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    expect_resp(tag, PING);
  endtask

  task automatic run_update(input string tag, input logic [7:0] hdr);
    send_byte(hdr, 0);
    model_mask = int'(hdr) % (1 << NUM_THREADS);
    check({tag, "/running"}, 64'(thread_running), 64'(model_mask));
    expect_resp(tag, ACK);
  endtask

  task automatic run_imem(input string tag, input logic [15:0] addr, input logic [15:0] data,
                          input int max_gap);
    int t;
    logic [NUM_THREADS-1:0] exp_strobe;
    send_byte(8'h40 | 8'($urandom_range(0, 63)), 0);
    for (int k = 0; k < BYTES; k++) send_byte(addr[8*k +: 8], $urandom_range(0, max_gap));
    for (int k = 0; k < BYTES; k++) send_byte(data[8*k +: 8], $urandom_range(0, max_gap));
    t = -1;
    for (int i = NUM_THREADS - 1; i >= 0; i--) if (((model_mask >> i) & 1) == 0) t = i;
    exp_strobe = (t < 0) ? '0 : NUM_THREADS'(1 << t);
    check({tag, "/strobe"}, 64'(imem_write_valid), 64'(exp_strobe));
    check({tag, "/addr"}, 64'(addr_out), 64'(addr));
    check({tag, "/data"}, 64'(imem_data), 64'(data));
    check({tag, "/bmem_idle"}, 64'(bmem_write_valid), 64'd0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
    step();
    check({tag, "/strobe_1cyc"}, 64'(imem_write_valid), 64'd0);
    check({tag, "/data_hold"}, 64'(imem_data), 64'(data));
    expect_resp(tag, (t < 0) ? NAK : ACK);
  endtask

  task automatic run_bmem(input string tag, input logic [15:0] addr,
                          input logic [BMEM_WORDS*BITWIDTH-1:0] block, input int max_gap);
    logic [BITWIDTH-1:0] word;
    send_byte(8'h80 | 8'($urandom_range(0, 63)), 0);
    for (int k = 0; k < BYTES; k++) send_byte(addr[8*k +: 8], $urandom_range(0, max_gap));
    for (int w = 0; w < BMEM_WORDS; w++) begin
      word = block[w*BITWIDTH +: BITWIDTH];
      for (int k = 0; k < BYTES; k++) send_byte(word[8*k +: 8], $urandom_range(0, max_gap));
    end
    model_bmem = block;
    check({tag, "/strobe"}, 64'(bmem_write_valid), 64'd1);
    check({tag, "/addr"}, 64'(addr_out), 64'(addr));
    check({tag, "/block"}, 64'(bmem_data), 64'(model_bmem));
    check({tag, "/imem_idle"}, 64'(imem_write_valid), 64'd0);
    step();
    check({tag, "/strobe_1cyc"}, 64'(bmem_write_valid), 64'd0);
    check({tag, "/block_hold"}, 64'(bmem_data), 64'(model_bmem));
    expect_resp(tag, ACK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/tx_valid"}, 64'(tx_valid), 64'd0);
    check({tag, "/tx_data"}, 64'(tx_data), 64'd0);
    check({tag, "/addr"}, 64'(addr_out), 64'd0);
    check({tag, "/imem_data"}, 64'(imem_data), 64'd0);
    check({tag, "/imem_wv"}, 64'(imem_write_valid), 64'd0);
    check({tag, "/bmem_data"}, 64'(bmem_data), 64'd0);
    check({tag, "/bmem_wv"}, 64'(bmem_write_valid), 64'd0);
    check({tag, "/running"}, 64'(thread_running), 64'd0);
    check({tag, "/busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [NUM_THREADS-1:0] strobe_seen;
    logic [BMEM_WORDS*BITWIDTH-1:0] blk;

    reset      = 1'b1;
    rx_data    = '0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    model_mask = 0;
    model_bmem = '0;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");

    // Free-thread selection: 000 -> t0, 011 -> t2, 111 -> NAK
    run_imem("imem_mask000", 16'h1234, 16'hABCD, 0);
    run_update("upd_011", 8'hC3);
    run_imem("imem_mask011", 16'h1234, 16'hABCD, 0);
    run_update("upd_111", 8'hC7);
    run_imem("imem_mask111", 16'h1234, 16'hABCD, 0);

    run_bmem("bmem_seq", 16'h0010, 64'h0807_0605_0403_0201, 0);

    // Inter-byte timeout aborts a partial IMEM command
    send_byte(8'h40, 0);
    send_byte(8'h34, 0);
    strobe_seen = '0;
    repeat (TIMEOUT_CYCLES - 1) begin
      step();
      strobe_seen |= imem_write_valid;
    end
    check("timeout/busy_before", 64'(busy), 64'd1);
    step();
    strobe_seen |= imem_write_valid;
    check("timeout/busy_after", 64'(busy), 64'd0);
    check("timeout/no_strobe", 64'(strobe_seen), 64'd0);
    expect_resp("timeout", NAK);
    run_ping("ping_after_to");

    // Reset coinciding with the last IMEM byte
    run_update("upd_000", 8'hC0);
    send_byte(8'h40, 0);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_byte(8'hCD, 0);
    rx_data  = 8'hAB;
    rx_valid = 1'b1;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    rx_valid = 1'b0;
    model_mask = 0;
    model_bmem = '0;
    check_all_zero("reset_last");
    step();
    check("reset_last/no_strobe", 64'(imem_write_valid), 64'd0);
    run_imem("imem_post_reset", 16'h1234, 16'hABCD, 1);

    // Pending response replaced, then held with tx_ready low
    send_byte(8'hC0, 0);
    check("latest/ack", 64'(tx_data), 64'(ACK));
    send_byte(8'h00, 1);
    send_byte(8'h00, 2);
    repeat (3) step();
    check("latest/held_valid", 64'(tx_valid), 64'd1);
    expect_resp("latest", PING);
    step();
    check("latest/single", 64'(tx_valid), 64'd0);

    // Randomized commands against the model
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: run_ping("rnd_ping");
        1: run_update("rnd_upd", 8'hC0 | 8'($urandom_range(0, 63)));
        2: run_imem("rnd_imem", 16'($urandom), 16'($urandom), 3);
        default: begin
          for (int w = 0; w < BMEM_WORDS; w++) blk[w*BITWIDTH +: BITWIDTH] = 16'($urandom);
          run_bmem("rnd_bmem", 16'($urandom), blk, 2);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
